// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb -- integer register file with a per-register busy scoreboard.
//
// Decode reads operands and busy bits combinationally. Issue marks a
// destination busy. Writeback ports write data and can clear busy.
// Register 0 is hardwired to zero. Writes or allocs that target it are
// dropped and raise a sticky error flag.
//
// Optional feature: define REGFILE_BYPASS_EN for write-through forwarding.
// With it, a same-cycle writeback value and the post-update busy bit appear
// on the read ports. Without it, the read ports show only registered state.
//
// Ports:
//   clk          clock; all state updates on posedge
//   rst          synchronous, active-high reset
//   rd_addr      NRD read addresses, port i at [i*AW +: AW]
//   rd_data      NRD read data words, port i at [i*XLEN +: XLEN]
//   rd_busy      busy bit of the register addressed by each read port
//   alloc_valid  issue strobe: mark alloc_addr busy
//   alloc_addr   destination register being allocated
//   wr_en        writeback enable, one per write port
//   wr_addr      NWR writeback addresses
//   wr_data      NWR writeback data words
//   wr_clr       writeback also clears busy of wr_addr (needs wr_en)
//   wr_x0_err    sticky: a write or alloc targeted register 0
// -----------------------------------------------------------------------------
module regfile_sb #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NRD*$clog2(NREG)-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]      rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic                     alloc_valid,
  input  logic [$clog2(NREG)-1:0]  alloc_addr,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR*$clog2(NREG)-1:0] wr_addr,
  input  logic [NWR*XLEN-1:0]      wr_data,
  input  logic [NWR-1:0]           wr_clr,
  output logic                     wr_x0_err
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            x0_hit;

  // Busy next state. Statement order encodes the priority: clears first,
  // then alloc overrides them, and register 0 is forced idle last.
  // NOTE: every always_comb output gets a full default before any
  // conditional update, so no path leaves it unassigned and no latch forms.
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && wr_clr[j]) busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
    end
    if (alloc_valid) busy_nxt[alloc_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    x0_hit = alloc_valid && (alloc_addr == '0);
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && (wr_addr[j*AW +: AW] == '0)) x0_hit = 1'b1;
    end
  end

  // Write ports are applied in ascending index order, so the highest
  // enabled port wins when addresses collide.
  // NOTE: sequential state uses non-blocking assignments only. The loop's
  // later writes then override earlier ones without races against readers.
  // NOTE: the array is reset explicitly because reset must read back zero for
  // every address. This makes it a flop array rather than an inferred RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
      busy      <= '0;
      wr_x0_err <= 1'b0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] != '0))
          regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
      busy <= busy_nxt;
      if (x0_hit) wr_x0_err <= 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rd_addr[i*AW +: AW] != '0) begin
        rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        rd_busy[i] = busy_nxt[rd_addr[i*AW +: AW]];
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW]))
            rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
        end
`else
        rd_busy[i] = busy[rd_addr[i*AW +: AW]];
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb -- directed self-checking bench for regfile_sb.
// The DUT is built with two write ports, so the port-collision case is
// reachable. Expected values are hand-computed constants. Same-cycle read
// expectations follow REGFILE_BYPASS_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic                 alloc_valid;
  logic [AW-1:0]        alloc_addr;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*XLEN-1:0]  wr_data;
  logic [NWR-1:0]       wr_clr;
  logic                 wr_x0_err;

  int n_checks = 0;
  int n_fails  = 0;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_clr      (wr_clr),
    .wr_x0_err   (wr_x0_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one posedge and settle outputs 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid = 1'b0;
    alloc_addr  = '0;
    wr_en       = '0;
    wr_addr     = '0;
    wr_data     = '0;
    wr_clr      = '0;
  endtask

  initial begin
    rst     = 1'b1;
    rd_addr = '0;
    idle_inputs();
    #2;
    step();
    rst = 1'b0;

    // 1. Reset state across every address.
    for (int a = 0; a < NREG; a++) begin
      rd_addr[0 +: AW]  = AW'(a);
      rd_addr[AW +: AW] = AW'(NREG - 1 - a);
      #1;
      check($sformatf("rst_data0_a%0d", a), rd_data[0 +: XLEN], 64'h0);
      check($sformatf("rst_data1_a%0d", a), rd_data[XLEN +: XLEN], 64'h0);
      check($sformatf("rst_busy_a%0d", a), {62'h0, rd_busy}, 64'h0);
    end
    check("rst_x0_err", {63'h0, wr_x0_err}, 64'h0);

    // 2. Write reg 5; same-cycle vs next-cycle visibility.
    wr_en             = 2'b01;
    wr_addr[0 +: AW]  = 5'd5;
    wr_data[0 +: XLEN] = 64'hDEAD_BEEF_0123_4567;
    rd_addr[0 +: AW]  = 5'd5;
    #1;
    check("wr5_same_cycle", rd_data[0 +: XLEN], BYP ? 64'hDEAD_BEEF_0123_4567 : 64'h0);
    step();
    idle_inputs();
    #1;
    check("wr5_next_cycle", rd_data[0 +: XLEN], 64'hDEAD_BEEF_0123_4567);
    check("wr5_no_x0_err", {63'h0, wr_x0_err}, 64'h0);

    // 3. Write to reg 0 is dropped and flagged.
    wr_en              = 2'b01;
    wr_addr[0 +: AW]   = 5'd0;
    wr_data[0 +: XLEN] = 64'h1;
    rd_addr[0 +: AW]   = 5'd0;
    #1;
    check("x0_same_cycle", rd_data[0 +: XLEN], 64'h0);
    step();
    idle_inputs();
    #1;
    check("x0_after_write", rd_data[0 +: XLEN], 64'h0);
    check("x0_err_set", {63'h0, wr_x0_err}, 64'h1);

    // 4. Alloc reg 7, then writeback with clear.
    alloc_valid       = 1'b1;
    alloc_addr        = 5'd7;
    rd_addr[AW +: AW] = 5'd7;
    #1;
    check("alloc7_same_busy", {63'h0, rd_busy[1]}, BYP ? 64'h1 : 64'h0);
    step();
    idle_inputs();
    #1;
    check("alloc7_busy", {63'h0, rd_busy[1]}, 64'h1);
    wr_en              = 2'b01;
    wr_clr             = 2'b01;
    wr_addr[0 +: AW]   = 5'd7;
    wr_data[0 +: XLEN] = 64'h42;
    #1;
    check("clr7_same_busy", {63'h0, rd_busy[1]}, BYP ? 64'h0 : 64'h1);
    check("clr7_same_data", rd_data[XLEN +: XLEN], BYP ? 64'h42 : 64'h0);
    step();
    idle_inputs();
    #1;
    check("clr7_busy", {63'h0, rd_busy[1]}, 64'h0);
    check("clr7_data", rd_data[XLEN +: XLEN], 64'h42);

    // wr_clr without wr_en must not clear busy.
    alloc_valid       = 1'b1;
    alloc_addr        = 5'd8;
    rd_addr[AW +: AW] = 5'd8;
    step();
    idle_inputs();
    wr_clr           = 2'b01;
    wr_addr[0 +: AW] = 5'd8;
    step();
    idle_inputs();
    #1;
    check("clr_no_en_busy8", {63'h0, rd_busy[1]}, 64'h1);

    // 5. Same-cycle alloc and clear on reg 9: alloc wins, data still written.
    alloc_valid        = 1'b1;
    alloc_addr         = 5'd9;
    wr_en              = 2'b01;
    wr_clr             = 2'b01;
    wr_addr[0 +: AW]   = 5'd9;
    wr_data[0 +: XLEN] = 64'h99;
    rd_addr[AW +: AW]  = 5'd9;
    step();
    idle_inputs();
    #1;
    check("alloc_clr9_busy", {63'h0, rd_busy[1]}, 64'h1);
    check("alloc_clr9_data", rd_data[XLEN +: XLEN], 64'h99);
    check("x0_err_sticky", {63'h0, wr_x0_err}, 64'h1);

    // 6. Both ports write reg 3; highest port wins.
    wr_en                 = 2'b11;
    wr_addr[0 +: AW]      = 5'd3;
    wr_addr[AW +: AW]     = 5'd3;
    wr_data[0 +: XLEN]    = 64'hA;
    wr_data[XLEN +: XLEN] = 64'hB;
    rd_addr[0 +: AW]      = 5'd3;
    step();
    idle_inputs();
    #1;
    check("collide3_data", rd_data[0 +: XLEN], 64'hB);

    // Reset with a concurrent write: reset dominates.
    rst                = 1'b1;
    wr_en              = 2'b01;
    wr_addr[0 +: AW]   = 5'd3;
    wr_data[0 +: XLEN] = 64'hC;
    alloc_valid        = 1'b1;
    alloc_addr         = 5'd0;
    step();
    rst = 1'b0;
    idle_inputs();
    #1;
    check("rst3_data", rd_data[0 +: XLEN], 64'h0);
    check("rst9_busy", {63'h0, rd_busy[1]}, 64'h0);
    check("rst_x0_err_clr", {63'h0, wr_x0_err}, 64'h0);
    rd_addr[0 +: AW]  = 5'd5;
    rd_addr[AW +: AW] = 5'd7;
    #1;
    check("rst5_data", rd_data[0 +: XLEN], 64'h0);
    check("rst7_data", rd_data[XLEN +: XLEN], 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
